// File: rtl/rv_ahb_rdata_align.sv
// ---------------------------------------------------------------------------
// rv_ahb_rdata_align
//
// Purpose:
//   Tracks the AHB address/data phase pipeline seen by the CPU bus interface.
//   For reads it returns the slave data with only the addressed byte lanes
//   kept, optionally lane-swapped for big-endian. Completed reads and read
//   errors are pulsed and counted.
//
// Ports:
//   cpu_clk          clock, rising edge
//   pad_cpu_rst_b    asynchronous active-low reset
//   biu_htrans       master HTRANS (bit 1 set = NONSEQ/SEQ)
//   biu_hwrite       master HWRITE
//   biu_hsize        master HSIZE (bits [1:0] used)
//   biu_haddr        master HADDR byte-offset bits
//   pad_biu_bigend_b 0 = big-endian lane order, sampled with the address
//   pad_hready       slave HREADY
//   pad_hresp        slave HRESP (bit 0 = ERROR)
//   pad_hrdata       slave read data
//   cnt_clr          synchronous clear of both statistics counters
//   align_hrdata     lane-aligned read data, zero outside the selected field
//   align_hresp      pad_hresp[0] passed through
//   rd_done          read data phase completed OKAY (combinational)
//   rd_err           read completed with ERROR (combinational)
//   dphase_busy      a data phase is outstanding
//   rd_cnt, err_cnt  saturating statistics counters
// ---------------------------------------------------------------------------
module rv_ahb_rdata_align #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                              cpu_clk,
  input  logic                              pad_cpu_rst_b,
  input  logic [1:0]                        biu_htrans,
  input  logic                              biu_hwrite,
  input  logic [2:0]                        biu_hsize,
  input  logic [$clog2(DATA_W/8)-1:0]       biu_haddr,
  input  logic                              pad_biu_bigend_b,
  input  logic                              pad_hready,
  input  logic [1:0]                        pad_hresp,
  input  logic [DATA_W-1:0]                 pad_hrdata,
  input  logic                              cnt_clr,
  output logic [DATA_W-1:0]                 align_hrdata,
  output logic                              align_hresp,
  output logic                              rd_done,
  output logic                              rd_err,
  output logic                              dphase_busy,
  output logic [CNT_W-1:0]                  rd_cnt,
  output logic [CNT_W-1:0]                  err_cnt
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  if (DATA_W != 32 && DATA_W != 64) begin : gBadWidth
    $error("rv_ahb_rdata_align: DATA_W must be 32 or 64");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_DP = 2'd1,
    WR_DP = 2'd2,
    ERR2  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            isRead_q, isRead_d;
  logic [1:0]      capSize_q, capSize_d;
  logic [OW-1:0]   capAddr_q, capAddr_d;
  logic            capBigendB_q, capBigendB_d;
  logic [CNT_W-1:0] rdCnt_q, errCnt_q;

  logic            addrAccept;
  state_e          acceptState;

  logic [7:0]      inLane  [NB];
  logic [7:0]      outLane [NB];
  int              fieldBytes;
  int              fieldOfs;
  logic            fieldOk;
  logic [OW-1:0]   srcLane;

  logic            unusedInputs;

  assign unusedInputs = ^{biu_hsize[2], pad_hresp[1]};

  assign addrAccept  = biu_htrans[1] & pad_hready;
  assign acceptState = addrAccept ? (biu_hwrite ? WR_DP : RD_DP) : IDLE;

  // State and captured address-phase attributes. Reset leaves a full-bus,
  // little-endian, offset-0 read context so the datapath is well defined.
  always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q      <= IDLE;
      isRead_q     <= 1'b0;
      capSize_q    <= 2'(OW);
      capAddr_q    <= '0;
      capBigendB_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      isRead_q     <= isRead_d;
      capSize_q    <= capSize_d;
      capAddr_q    <= capAddr_d;
      capBigendB_q <= capBigendB_d;
    end
  end

  // Next-state logic. HREADY high ends the current data phase and, if an
  // address phase is accepted on the same edge, starts the next one with no
  // bubble. The first cycle of a two-cycle ERROR response parks in ERR2; the
  // read/write flag is untouched there because no address can be accepted
  // while HREADY is low.
  always_comb begin
    state_d      = state_q;
    isRead_d     = isRead_q;
    capSize_d    = capSize_q;
    capAddr_d    = capAddr_q;
    capBigendB_d = capBigendB_q;

    if (addrAccept) begin
      isRead_d = ~biu_hwrite;
      if (!biu_hwrite) begin
        capSize_d    = biu_hsize[1:0];
        capAddr_d    = biu_haddr;
        capBigendB_d = pad_biu_bigend_b;
      end
    end

    if (pad_hready) begin
      state_d = acceptState;
    end else if ((state_q == RD_DP || state_q == WR_DP) && pad_hresp[0]) begin
      state_d = ERR2;
    end
  end

  assign rd_done     = (state_q == RD_DP) & pad_hready & ~pad_hresp[0];
  assign rd_err      = (state_q == ERR2) & isRead_q & pad_hready;
  assign dphase_busy = (state_q != IDLE);
  assign align_hresp = pad_hresp[0];

  for (genvar g = 0; g < NB; g++) begin : gLanes
    assign inLane[g]                = pad_hrdata[8*g +: 8];
    assign align_hrdata[8*g +: 8]   = outLane[g];
  end

  // Lane selection. The field keeps its own lanes; big-endian mirrors the
  // source within the bus so destination lane addr+k reads lane
  // NB-bytes-addr+k. Data is only driven on the completing read cycle, and
  // misaligned or oversized fields return zero.
  always_comb begin
    fieldBytes = 1 << capSize_q;
    fieldOfs   = int'(capAddr_q);
    fieldOk    = (fieldBytes <= NB) && ((fieldOfs & (fieldBytes - 1)) == 0);
    srcLane    = '0;
    for (int j = 0; j < NB; j++) begin
      outLane[j] = 8'h00;
    end
    if (state_q == RD_DP && pad_hready && fieldOk) begin
      for (int j = 0; j < NB; j++) begin
        if (j >= fieldOfs && j < fieldOfs + fieldBytes) begin
          if (capBigendB_q) begin
            srcLane = OW'(j);
          end else begin
            srcLane = OW'(NB - fieldBytes - fieldOfs + (j - fieldOfs));
          end
          outLane[j] = inLane[srcLane];
        end
      end
    end
  end

  // Saturating statistics counters; clear wins over a coincident increment.
  always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      rdCnt_q  <= '0;
      errCnt_q <= '0;
    end else if (cnt_clr) begin
      rdCnt_q  <= '0;
      errCnt_q <= '0;
    end else begin
      if (rd_done && rdCnt_q != '1) begin
        rdCnt_q <= rdCnt_q + 1'b1;
      end
      if (rd_err && errCnt_q != '1) begin
        errCnt_q <= errCnt_q + 1'b1;
      end
    end
  end

  assign rd_cnt  = rdCnt_q;
  assign err_cnt = errCnt_q;

endmodule

// File: tb/tb_rv_ahb_rdata_align.sv
// ---------------------------------------------------------------------------
// tb_rv_ahb_rdata_align
//
// Purpose:
//   Self-checking bench for rv_ahb_rdata_align. A 32-bit instance with 4-bit
//   counters covers lane selection, wait states, pipelining, errors,
//   counter saturation/clear and reset; a 64-bit instance covers wide lanes.
// ---------------------------------------------------------------------------
module tb_rv_ahb_rdata_align;

  logic cpu_clk = 1'b0;
  logic pad_cpu_rst_b;

  always #5 cpu_clk = ~cpu_clk;

  // 32-bit instance signals
  logic [1:0]  aHtrans;
  logic        aHwrite;
  logic [2:0]  aHsize;
  logic [1:0]  aHaddr;
  logic        aBigendB;
  logic        aHready;
  logic [1:0]  aHresp;
  logic [31:0] aHrdata;
  logic        aCntClr;
  logic [31:0] aAlign;
  logic        aHrespO;
  logic        aRdDone;
  logic        aRdErr;
  logic        aBusy;
  logic [3:0]  aRdCnt;
  logic [3:0]  aErrCnt;

  // 64-bit instance signals
  logic [1:0]  bHtrans;
  logic        bHwrite;
  logic [2:0]  bHsize;
  logic [2:0]  bHaddr;
  logic        bBigendB;
  logic        bHready;
  logic [1:0]  bHresp;
  logic [63:0] bHrdata;
  logic        bCntClr;
  logic [63:0] bAlign;
  logic        bHrespO;
  logic        bRdDone;
  logic        bRdErr;
  logic        bBusy;
  logic [15:0] bRdCnt;
  logic [15:0] bErrCnt;

  int nChecks = 0;
  int nFails  = 0;
  int expRd;
  int expErr;

  rv_ahb_rdata_align #(.DATA_W(32), .CNT_W(4)) dut32 (
    .cpu_clk          (cpu_clk),
    .pad_cpu_rst_b    (pad_cpu_rst_b),
    .biu_htrans       (aHtrans),
    .biu_hwrite       (aHwrite),
    .biu_hsize        (aHsize),
    .biu_haddr        (aHaddr),
    .pad_biu_bigend_b (aBigendB),
    .pad_hready       (aHready),
    .pad_hresp        (aHresp),
    .pad_hrdata       (aHrdata),
    .cnt_clr          (aCntClr),
    .align_hrdata     (aAlign),
    .align_hresp      (aHrespO),
    .rd_done          (aRdDone),
    .rd_err           (aRdErr),
    .dphase_busy      (aBusy),
    .rd_cnt           (aRdCnt),
    .err_cnt          (aErrCnt)
  );

  rv_ahb_rdata_align #(.DATA_W(64), .CNT_W(16)) dut64 (
    .cpu_clk          (cpu_clk),
    .pad_cpu_rst_b    (pad_cpu_rst_b),
    .biu_htrans       (bHtrans),
    .biu_hwrite       (bHwrite),
    .biu_hsize        (bHsize),
    .biu_haddr        (bHaddr),
    .pad_biu_bigend_b (bBigendB),
    .pad_hready       (bHready),
    .pad_hresp        (bHresp),
    .pad_hrdata       (bHrdata),
    .cnt_clr          (bCntClr),
    .align_hrdata     (bAlign),
    .align_hresp      (bHrespO),
    .rd_done          (bRdDone),
    .rd_err           (bRdErr),
    .dphase_busy      (bBusy),
    .rd_cnt           (bRdCnt),
    .err_cnt          (bErrCnt)
  );

  typedef struct {
    string       name;
    logic [2:0]  size;
    logic [1:0]  addr;
    logic        bigendB;
    logic [31:0] rdata;
    logic [31:0] expAlign;
  } vecA_t;

  typedef struct {
    string       name;
    logic [2:0]  size;
    logic [2:0]  addr;
    logic        bigendB;
    logic [63:0] rdata;
    logic [63:0] expAlign;
  } vecB_t;

  vecA_t vecsA [13];
  vecB_t vecsB [5];

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive the 32-bit bus and let combinational outputs settle.
  task automatic applyStimulus(input logic [1:0] htrans, input logic hwrite,
                               input logic [2:0] hsize, input logic [1:0] haddr,
                               input logic bigendB, input logic hready,
                               input logic [1:0] hresp, input logic [31:0] hrdata,
                               input logic cntClr);
    aHtrans  = htrans;
    aHwrite  = hwrite;
    aHsize   = hsize;
    aHaddr   = haddr;
    aBigendB = bigendB;
    aHready  = hready;
    aHresp   = hresp;
    aHrdata  = hrdata;
    aCntClr  = cntClr;
    #1;
  endtask

  task automatic applyStimulusB(input logic [1:0] htrans, input logic [2:0] hsize,
                                input logic [2:0] haddr, input logic bigendB,
                                input logic hready, input logic [63:0] hrdata);
    bHtrans  = htrans;
    bHwrite  = 1'b0;
    bHsize   = hsize;
    bHaddr   = haddr;
    bBigendB = bigendB;
    bHready  = hready;
    bHresp   = 2'b00;
    bHrdata  = hrdata;
    bCntClr  = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  function automatic int satInc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  // One single-beat read; data-phase address/size/endian inputs are set to
  // different values so only the captured ones can produce the result.
  task automatic runReadA(input vecA_t v);
    applyStimulus(2'd2, 1'b0, v.size, v.addr, v.bigendB, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    applyStimulus(2'd0, 1'b0, {1'b0, ~v.size[1:0]}, ~v.addr, ~v.bigendB, 1'b1, 2'b00,
                  v.rdata, 1'b0);
    checkOutput({v.name, "_align"}, 64'(aAlign), 64'(v.expAlign));
    checkOutput({v.name, "_rd_done"}, 64'(aRdDone), 64'd1);
    tick();
    expRd = satInc(expRd);
    checkOutput({v.name, "_rd_cnt"}, 64'(aRdCnt), 64'(expRd));
  endtask

  initial begin
    vecsA[0]  = '{"le_b_a2",    3'd0, 2'd2, 1'b1, 32'hAABBCCDD, 32'h00BB0000};
    vecsA[1]  = '{"be_h_a0",    3'd1, 2'd0, 1'b0, 32'h11223344, 32'h00001122};
    vecsA[2]  = '{"le_w_a0",    3'd2, 2'd0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecsA[3]  = '{"be_w_a0",    3'd2, 2'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecsA[4]  = '{"le_h_a2",    3'd1, 2'd2, 1'b1, 32'h11223344, 32'h11220000};
    vecsA[5]  = '{"be_h_a2",    3'd1, 2'd2, 1'b0, 32'h11223344, 32'h33440000};
    vecsA[6]  = '{"be_b_a0",    3'd0, 2'd0, 1'b0, 32'hAABBCCDD, 32'h000000AA};
    vecsA[7]  = '{"be_b_a3",    3'd0, 2'd3, 1'b0, 32'hAABBCCDD, 32'hDD000000};
    vecsA[8]  = '{"le_b_a1",    3'd0, 2'd1, 1'b1, 32'hAABBCCDD, 32'h0000CC00};
    vecsA[9]  = '{"mis_h_a1",   3'd1, 2'd1, 1'b1, 32'hAABBCCDD, 32'h00000000};
    vecsA[10] = '{"mis_w_a2",   3'd2, 2'd2, 1'b1, 32'hAABBCCDD, 32'h00000000};
    vecsA[11] = '{"over_d_a0",  3'd3, 2'd0, 1'b1, 32'hAABBCCDD, 32'h00000000};
    vecsA[12] = '{"be_b_a1",    3'd0, 2'd1, 1'b0, 32'hAABBCCDD, 32'h0000BB00};

    vecsB[0]  = '{"w64_le_w_a4",  3'd2, 3'd4, 1'b1, 64'h0123456789ABCDEF, 64'h0123456700000000};
    vecsB[1]  = '{"w64_mis_w_a2", 3'd2, 3'd2, 1'b1, 64'h0123456789ABCDEF, 64'h0};
    vecsB[2]  = '{"w64_le_d_a0",  3'd3, 3'd0, 1'b1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecsB[3]  = '{"w64_be_w_a0",  3'd2, 3'd0, 1'b0, 64'h0123456789ABCDEF, 64'h0000000001234567};
    vecsB[4]  = '{"w64_be_b_a5",  3'd0, 3'd5, 1'b0, 64'h0123456789ABCDEF, 64'h0000AB0000000000};

    expRd  = 0;
    expErr = 0;

    // Reset state with a busy-looking bus.
    pad_cpu_rst_b = 1'b0;
    applyStimulusB(2'd0, 3'd3, 3'd0, 1'b1, 1'b1, 64'h0);
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'hFFFFFFFF, 1'b0);
    tick();
    checkOutput("rst_align", 64'(aAlign), 64'd0);
    checkOutput("rst_rd_done", 64'(aRdDone), 64'd0);
    checkOutput("rst_rd_err", 64'(aRdErr), 64'd0);
    checkOutput("rst_busy", 64'(aBusy), 64'd0);
    checkOutput("rst_rd_cnt", 64'(aRdCnt), 64'd0);
    checkOutput("rst_err_cnt", 64'(aErrCnt), 64'd0);
    @(negedge cpu_clk);
    pad_cpu_rst_b = 1'b1;
    tick();

    $display("[TB] lane selection table");
    for (int i = 0; i < 13; i++) begin
      runReadA(vecsA[i]);
    end

    $display("[TB] wait states with pipelined SEQ read");
    applyStimulus(2'd2, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    for (int w = 0; w < 2; w++) begin
      applyStimulus(2'd3, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0, 2'b00, 32'h12345678, 1'b0);
      checkOutput("wait_align", 64'(aAlign), 64'd0);
      checkOutput("wait_rd_done", 64'(aRdDone), 64'd0);
      checkOutput("wait_busy", 64'(aBusy), 64'd1);
      tick();
    end
    applyStimulus(2'd3, 1'b0, 3'd0, 2'd1, 1'b1, 1'b1, 2'b00, 32'hCAFEF00D, 1'b0);
    checkOutput("wait_done_align", 64'(aAlign), 64'hCAFEF00D);
    checkOutput("wait_done_rd_done", 64'(aRdDone), 64'd1);
    tick();
    expRd = satInc(expRd);
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b1, 2'b00, 32'hAABBCCDD, 1'b0);
    checkOutput("pipe_align", 64'(aAlign), 64'h0000CC00);
    checkOutput("pipe_rd_done", 64'(aRdDone), 64'd1);
    tick();
    expRd = satInc(expRd);
    checkOutput("pipe_rd_cnt", 64'(aRdCnt), 64'(expRd));

    $display("[TB] read error response");
    applyStimulus(2'd2, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b0, 2'b01, 32'h55555555, 1'b0);
    checkOutput("err1_rd_done", 64'(aRdDone), 64'd0);
    checkOutput("err1_rd_err", 64'(aRdErr), 64'd0);
    checkOutput("err1_hresp", 64'(aHrespO), 64'd1);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b01, 32'h55555555, 1'b0);
    checkOutput("err2_rd_err", 64'(aRdErr), 64'd1);
    checkOutput("err2_rd_done", 64'(aRdDone), 64'd0);
    checkOutput("err2_busy", 64'(aBusy), 64'd1);
    checkOutput("err2_align", 64'(aAlign), 64'd0);
    tick();
    expErr++;
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    checkOutput("err_after_rd_err", 64'(aRdErr), 64'd0);
    checkOutput("err_after_busy", 64'(aBusy), 64'd0);
    checkOutput("err_err_cnt", 64'(aErrCnt), 64'(expErr));
    checkOutput("err_rd_cnt", 64'(aRdCnt), 64'(expRd));

    $display("[TB] writes do not count as reads");
    applyStimulus(2'd2, 1'b1, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'hFFFFFFFF, 1'b0);
    checkOutput("wr_rd_done", 64'(aRdDone), 64'd0);
    checkOutput("wr_align", 64'(aAlign), 64'd0);
    checkOutput("wr_busy", 64'(aBusy), 64'd1);
    tick();
    applyStimulus(2'd2, 1'b1, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0);
    checkOutput("wrerr_rd_err", 64'(aRdErr), 64'd0);
    checkOutput("wrerr_busy", 64'(aBusy), 64'd1);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    checkOutput("wrerr_err_cnt", 64'(aErrCnt), 64'(expErr));
    checkOutput("wrerr_rd_cnt", 64'(aRdCnt), 64'(expRd));

    $display("[TB] counter saturation");
    for (int i = 0; i < 3; i++) begin
      runReadA(vecsA[2]);
    end

    $display("[TB] clear coincident with rd_done");
    applyStimulus(2'd2, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h13572468, 1'b1);
    checkOutput("clr_rd_done", 64'(aRdDone), 64'd1);
    tick();
    expRd  = 0;
    expErr = 0;
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    checkOutput("clr_rd_cnt", 64'(aRdCnt), 64'(expRd));
    checkOutput("clr_err_cnt", 64'(aErrCnt), 64'(expErr));

    $display("[TB] reset during a read data phase");
    runReadA(vecsA[0]);
    applyStimulus(2'd2, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b0, 2'b00, 32'h89ABCDEF, 1'b0);
    checkOutput("mid_busy", 64'(aBusy), 64'd1);
    #2;
    pad_cpu_rst_b = 1'b0;
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 2'b00, 32'h89ABCDEF, 1'b0);
    expRd = 0;
    checkOutput("mid_rst_busy", 64'(aBusy), 64'd0);
    checkOutput("mid_rst_rd_done", 64'(aRdDone), 64'd0);
    checkOutput("mid_rst_align", 64'(aAlign), 64'd0);
    checkOutput("mid_rst_rd_cnt", 64'(aRdCnt), 64'd0);
    tick();
    @(negedge cpu_clk);
    pad_cpu_rst_b = 1'b1;
    applyStimulus(2'd2, 1'b0, 3'd0, 2'd2, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    applyStimulus(2'd0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b1, 2'b00, 32'hAABBCCDD, 1'b0);
    checkOutput("post_rst_align", 64'(aAlign), 64'h00BB0000);
    checkOutput("post_rst_rd_done", 64'(aRdDone), 64'd1);
    tick();
    expRd = satInc(expRd);
    checkOutput("post_rst_rd_cnt", 64'(aRdCnt), 64'(expRd));

    $display("[TB] 64-bit lane selection");
    for (int i = 0; i < 5; i++) begin
      applyStimulusB(2'd2, vecsB[i].size, vecsB[i].addr, vecsB[i].bigendB, 1'b1, 64'h0);
      tick();
      applyStimulusB(2'd0, {1'b0, ~vecsB[i].size[1:0]}, ~vecsB[i].addr, ~vecsB[i].bigendB,
                     1'b1, vecsB[i].rdata);
      checkOutput({vecsB[i].name, "_align"}, bAlign, vecsB[i].expAlign);
      checkOutput({vecsB[i].name, "_rd_done"}, 64'(bRdDone), 64'd1);
      tick();
    end
    checkOutput("w64_rd_cnt", 64'(bRdCnt), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
